// File: rtl/pio_irq_servicer_pkg.sv
// Shared types and constants for the PIO interrupt servicer: FSM states,
// slave register map and the bus payload with its idle value.
package pio_irq_servicer_pkg;

    localparam int unsigned BUS_AW = 2;
    localparam int unsigned BUS_DW = 32;

    localparam logic [BUS_AW-1:0] ADDR_DATA = 2'd0;
    localparam logic [BUS_AW-1:0] ADDR_MASK = 2'd2;
    localparam logic [BUS_AW-1:0] ADDR_CAP  = 2'd3;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WMASK,
        ST_RD_CAP,
        ST_CLR,
        ST_RD_LVL,
        ST_EMIT
    } state_e;

    typedef struct packed {
        logic              chipselect;
        logic              write_n;
        logic [BUS_AW-1:0] address;
        logic [BUS_DW-1:0] writedata;
    } bus_t;

    localparam bus_t BUS_IDLE = '{chipselect: 1'b0, write_n: 1'b1, address: '0, writedata: '0};

    function automatic bus_t bus_write(input logic [BUS_AW-1:0] addr, input logic [BUS_DW-1:0] data);
        bus_t b;
        b            = BUS_IDLE;
        b.chipselect = 1'b1;
        b.write_n    = 1'b0;
        b.address    = addr;
        b.writedata  = data;
        return b;
    endfunction

    function automatic bus_t bus_read(input logic [BUS_AW-1:0] addr);
        bus_t b;
        b            = BUS_IDLE;
        b.chipselect = 1'b1;
        b.address    = addr;
        return b;
    endfunction

endpackage

// File: rtl/pio_read_seq.sv
// Read-latency counter: flags the last cycle of a held read, when readdata is valid.
module pio_read_seq
    import pio_irq_servicer_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic active,
    output logic sample_c
);

    localparam int unsigned CNT_W = $clog2(READ_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LATENCY);

    logic [CNT_W-1:0] cnt_q;

    assign sample_c = active && (cnt_q == CNT_LAST);

    // Restarts at zero after every sample so back-to-back reads reuse it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (sample_c) begin
            cnt_q <= '0;
        end else if (active) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pio_irq_servicer.sv
// Avalon-MM initiator servicing an edge-capturing PIO slave: programs the irq mask,
// then turns each irq into one {edges, levels} event on a valid/ready stream.
module pio_irq_servicer
    import pio_irq_servicer_pkg::*;
#(
    parameter int unsigned            WIDTH        = 4,
    parameter logic [WIDTH-1:0]       MASK_INIT    = {WIDTH{1'b1}},
    parameter int unsigned            READ_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [1:0]       address,
    output logic             chipselect,
    output logic             write_n,
    output logic [31:0]      writedata,
    input  logic [31:0]      readdata,
    input  logic             irq,
    input  logic [WIDTH-1:0] mask_data,
    input  logic             mask_valid,
    output logic             mask_ready,
    output logic [WIDTH-1:0] event_edges,
    output logic [WIDTH-1:0] event_level,
    output logic             event_valid,
    input  logic             event_ready,
    output logic             busy
);

    state_e           state_q, state_d;
    bus_t             bus_q, bus_d;
    logic             init_done_q, init_done_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] lvl_q, lvl_d;
    logic             read_active;
    logic             sample_c;
    logic             unused_readdata;

    assign unused_readdata = ^readdata;
    assign read_active     = (state_q == ST_RD_CAP) || (state_q == ST_RD_LVL);

    pio_read_seq #(
        .READ_LATENCY(READ_LATENCY)
    ) u_read_seq (
        .clk     (clk),
        .reset_n (reset_n),
        .active  (read_active),
        .sample_c(sample_c)
    );

    // Bus outputs are computed for the state being entered, so they line up with it.
    always_comb begin
        state_d     = state_q;
        bus_d       = BUS_IDLE;
        init_done_d = init_done_q;
        cap_d       = cap_q;
        lvl_d       = lvl_q;
        case (state_q)
            ST_INIT: begin
                if (!init_done_q) begin
                    bus_d       = bus_write(ADDR_MASK, BUS_DW'(MASK_INIT));
                    init_done_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (mask_valid && mask_ready) begin
                    bus_d   = bus_write(ADDR_MASK, BUS_DW'(mask_data));
                    state_d = ST_WMASK;
                end else if (irq) begin
                    bus_d   = bus_read(ADDR_CAP);
                    state_d = ST_RD_CAP;
                end
            end
            ST_WMASK: begin
                state_d = ST_IDLE;
            end
            ST_RD_CAP: begin
                if (sample_c) begin
                    cap_d = readdata[WIDTH-1:0];
                    if (readdata[WIDTH-1:0] != '0) begin
                        bus_d   = bus_write(ADDR_CAP, '0);
                        state_d = ST_CLR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    bus_d = bus_read(ADDR_CAP);
                end
            end
            ST_CLR: begin
                bus_d   = bus_read(ADDR_DATA);
                state_d = ST_RD_LVL;
            end
            ST_RD_LVL: begin
                if (sample_c) begin
                    lvl_d   = readdata[WIDTH-1:0];
                    state_d = ST_EMIT;
                end else begin
                    bus_d = bus_read(ADDR_DATA);
                end
            end
            ST_EMIT: begin
                if (event_valid && event_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            bus_q       <= BUS_IDLE;
            init_done_q <= 1'b0;
            cap_q       <= '0;
            lvl_q       <= '0;
            busy        <= 1'b1;
            mask_ready  <= 1'b0;
            event_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_q       <= bus_d;
            init_done_q <= init_done_d;
            cap_q       <= cap_d;
            lvl_q       <= lvl_d;
            busy        <= (state_d != ST_IDLE);
            mask_ready  <= (state_d == ST_IDLE);
            event_valid <= (state_d == ST_EMIT);
        end
    end

    assign chipselect  = bus_q.chipselect;
    assign write_n     = bus_q.write_n;
    assign address     = bus_q.address;
    assign writedata   = bus_q.writedata;
    assign event_edges = cap_q;
    assign event_level = lvl_q;

endmodule

// File: tb/tb_pio_irq_servicer.sv
// Bench for pio_irq_servicer: two instances (READ_LATENCY 1 and 2), each with a
// behavioural edge-capture PIO slave, driven through the same directed scenarios.
module tb_pio_irq_servicer;

    localparam int unsigned W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n       [2];
    logic [1:0]   address     [2];
    logic         cs          [2];
    logic         write_n     [2];
    logic [31:0]  writedata   [2];
    logic [31:0]  readdata    [2];
    logic         irq         [2];
    logic [W-1:0] mask_data   [2];
    logic         mask_valid  [2];
    logic         mask_ready  [2];
    logic [W-1:0] event_edges [2];
    logic [W-1:0] event_level [2];
    logic         event_valid [2];
    logic         event_ready [2];
    logic         busy        [2];

    logic [W-1:0] in_port     [2];
    logic         irq_force   [2];

    logic [W-1:0] s_mask    [2]    = '{default: '0};
    logic [W-1:0] s_cap     [2]    = '{default: '0};
    logic [W-1:0] prev_in   [2]    = '{default: '0};
    logic [31:0]  rd_pipe   [2][2] = '{default: '0};
    logic [31:0]  last_mask [2]    = '{default: '0};
    int           wr_mask_n [2]    = '{default: 0};
    int           wr_cap_n  [2]    = '{default: 0};
    int           rd_cap_n  [2]    = '{default: 0};
    int           rd_dat_n  [2]    = '{default: 0};

    int n_checks = 0;
    int n_pass   = 0;
    int cur_k    = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pio_irq_servicer #(
            .WIDTH       (W),
            .MASK_INIT   (4'hF),
            .READ_LATENCY(g + 1)
        ) u_dut (
            .clk        (clk),
            .reset_n    (rst_n[g]),
            .address    (address[g]),
            .chipselect (cs[g]),
            .write_n    (write_n[g]),
            .writedata  (writedata[g]),
            .readdata   (readdata[g]),
            .irq        (irq[g]),
            .mask_data  (mask_data[g]),
            .mask_valid (mask_valid[g]),
            .mask_ready (mask_ready[g]),
            .event_edges(event_edges[g]),
            .event_level(event_level[g]),
            .event_valid(event_valid[g]),
            .event_ready(event_ready[g]),
            .busy       (busy[g])
        );
    end

    // Upper readdata bits carry junk the servicer must ignore.
    function automatic logic [31:0] rd_mux(input int i);
        case (address[i])
            2'd0:    return 32'hDEAD_0000 | 32'(in_port[i]);
            2'd2:    return 32'hDEAD_0000 | 32'(s_mask[i]);
            2'd3:    return 32'hDEAD_0000 | 32'(s_cap[i]);
            default: return 32'hDEAD_0000;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            irq[i]      = (|(s_cap[i] & s_mask[i])) | irq_force[i];
            readdata[i] = rd_pipe[i][i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            prev_in[i]    <= in_port[i];
            rd_pipe[i][0] <= rd_mux(i);
            rd_pipe[i][1] <= rd_pipe[i][0];
            if (cs[i] && !write_n[i] && address[i] == 2'd3) begin
                s_cap[i]    <= '0;
                wr_cap_n[i] <= wr_cap_n[i] + 1;
            end else begin
                s_cap[i] <= s_cap[i] | (in_port[i] & ~prev_in[i]);
            end
            if (cs[i] && !write_n[i] && address[i] == 2'd2) begin
                s_mask[i]    <= writedata[i][W-1:0];
                last_mask[i] <= writedata[i];
                wr_mask_n[i] <= wr_mask_n[i] + 1;
            end
            if (cs[i] && write_n[i] && address[i] == 2'd3) rd_cap_n[i] <= rd_cap_n[i] + 1;
            if (cs[i] && write_n[i] && address[i] == 2'd0) rd_dat_n[i] <= rd_dat_n[i] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL [L%0d] %s: got 0x%0h expected 0x%0h", cur_k + 1, tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int k, input int limit, output int n);
        n = 0;
        while (event_valid[k] !== 1'b1 && n < limit) begin
            step();
            n++;
        end
    endtask

    task automatic run_inst(input int k);
        int   lat;
        int   n;
        int   s_rc, s_wc, s_rd, s_wm;
        logic stable, seen;
        lat   = k + 1;
        cur_k = k;

        // reset values, then the INIT mask write
        check("rst busy", 32'(busy[k]), 32'd1);
        check("rst cs", 32'(cs[k]), 32'd0);
        check("rst write_n", 32'(write_n[k]), 32'd1);
        check("rst addr", 32'(address[k]), 32'd0);
        check("rst wdata", writedata[k], 32'd0);
        check("rst valid", 32'(event_valid[k]), 32'd0);
        check("rst edges", 32'(event_edges[k]), 32'd0);
        check("rst mask_ready", 32'(mask_ready[k]), 32'd0);
        rst_n[k] = 1'b1;
        step();
        check("init cs", 32'(cs[k]), 32'd1);
        check("init write_n", 32'(write_n[k]), 32'd0);
        check("init addr", 32'(address[k]), 32'd2);
        check("init wdata", writedata[k], 32'hF);
        check("init busy", 32'(busy[k]), 32'd1);
        step();
        check("idle cs", 32'(cs[k]), 32'd0);
        check("idle busy", 32'(busy[k]), 32'd0);
        check("idle mask_ready", 32'(mask_ready[k]), 32'd1);
        step();
        check("init write count", 32'(wr_mask_n[k]), 32'd1);

        // single edge on bit 1 with event_ready high
        event_ready[k] = 1'b1;
        s_rc = rd_cap_n[k]; s_wc = wr_cap_n[k]; s_rd = rd_dat_n[k];
        in_port[k] = 4'h2;
        step();
        wait_valid(k, 30, n);
        check("ev1 latency", 32'(n), 32'(4 + 2 * lat));
        check("ev1 edges", 32'(event_edges[k]), 32'h2);
        check("ev1 level", 32'(event_level[k]), 32'h2);
        check("ev1 cap reads", 32'(rd_cap_n[k] - s_rc), 32'(lat + 1));
        check("ev1 clr writes", 32'(wr_cap_n[k] - s_wc), 32'd1);
        check("ev1 lvl reads", 32'(rd_dat_n[k] - s_rd), 32'(lat + 1));
        step();
        check("ev1 done valid", 32'(event_valid[k]), 32'd0);
        check("ev1 done busy", 32'(busy[k]), 32'd0);

        // back-pressure: second edge on bit 3 while the first event is held
        event_ready[k] = 1'b0;
        in_port[k] = 4'h0;
        step();
        in_port[k] = 4'h2;
        step();
        wait_valid(k, 30, n);
        check("bp ev1 latency", 32'(n), 32'(4 + 2 * lat));
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) in_port[k] = 4'hA;
            step();
            stable &= (event_valid[k] === 1'b1) && (event_edges[k] === 4'h2) && (event_level[k] === 4'h2);
        end
        check("bp ev1 stable", 32'(stable), 32'd1);
        event_ready[k] = 1'b1;
        step();
        check("bp ev1 taken", 32'(event_valid[k]), 32'd0);
        wait_valid(k, 30, n);
        check("bp ev2 latency", 32'(n), 32'(4 + 2 * lat));
        check("bp ev2 edges", 32'(event_edges[k]), 32'h8);
        check("bp ev2 level", 32'(event_level[k]), 32'hA);
        step();

        // mask update and irq in the same IDLE cycle: mask write wins
        s_wm = wr_mask_n[k];
        in_port[k] = 4'hB;
        step();
        check("mix irq high", 32'(irq[k]), 32'd1);
        check("mix mask_ready", 32'(mask_ready[k]), 32'd1);
        mask_valid[k] = 1'b1;
        mask_data[k]  = 4'h1;
        step();
        mask_valid[k] = 1'b0;
        check("mix wr cs", 32'(cs[k]), 32'd1);
        check("mix wr write_n", 32'(write_n[k]), 32'd0);
        check("mix wr addr", 32'(address[k]), 32'd2);
        check("mix wr data", writedata[k], 32'h1);
        wait_valid(k, 30, n);
        check("mix ev latency", 32'(n), 32'(5 + 2 * lat));
        check("mix ev edges", 32'(event_edges[k]), 32'h1);
        check("mix ev level", 32'(event_level[k]), 32'hB);
        check("mix mask writes", 32'(wr_mask_n[k] - s_wm), 32'd1);
        step();

        // spurious irq: capture register reads back zero
        s_rc = rd_cap_n[k]; s_wc = wr_cap_n[k]; s_rd = rd_dat_n[k];
        irq_force[k] = 1'b1;
        step();
        irq_force[k] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            seen |= (event_valid[k] === 1'b1);
        end
        check("spur cap reads", 32'(rd_cap_n[k] - s_rc), 32'(lat + 1));
        check("spur clr writes", 32'(wr_cap_n[k] - s_wc), 32'd0);
        check("spur lvl reads", 32'(rd_dat_n[k] - s_rd), 32'd0);
        check("spur no event", 32'(seen), 32'd0);
        check("spur busy", 32'(busy[k]), 32'd0);

        // reset asserted during the clear write
        in_port[k] = 4'hA;
        step();
        in_port[k] = 4'hB;
        step();
        n = 0;
        while (!(cs[k] === 1'b1 && write_n[k] === 1'b0 && address[k] === 2'd3) && n < 20) begin
            step();
            n++;
        end
        check("clr reached", 32'(n < 20), 32'd1);
        rst_n[k] = 1'b0;
        #1;
        check("abort cs", 32'(cs[k]), 32'd0);
        check("abort write_n", 32'(write_n[k]), 32'd1);
        check("abort addr", 32'(address[k]), 32'd0);
        check("abort wdata", writedata[k], 32'd0);
        check("abort valid", 32'(event_valid[k]), 32'd0);
        check("abort busy", 32'(busy[k]), 32'd1);
        step();
        step();
        rst_n[k] = 1'b1;
        step();
        check("reinit addr", 32'(address[k]), 32'd2);
        check("reinit write_n", 32'(write_n[k]), 32'd0);
        check("reinit wdata", writedata[k], 32'hF);
        wait_valid(k, 40, n);
        check("reinit ev valid", 32'(event_valid[k]), 32'd1);
        check("reinit ev edges", 32'(event_edges[k]), 32'h1);
        check("reinit ev level", 32'(event_level[k]), 32'hB);
        step();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_n[i]       = 1'b0;
            in_port[i]     = '0;
            irq_force[i]   = 1'b0;
            mask_data[i]   = '0;
            mask_valid[i]  = 1'b0;
            event_ready[i] = 1'b0;
        end
        repeat (3) step();
        for (int k = 0; k < 2; k++) run_inst(k);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pio_irq_servicer.md
# pio_irq_servicer

Avalon-MM initiator that services an edge-capturing PIO input slave (data at address 0, irq mask at 2, edge capture at 3). After reset it programs the irq mask. On each slave irq it reads the edge-capture register, clears it, samples the live input levels, and presents the result as one event on a valid/ready stream. It sits between the key/switch PIO slave and control logic that has no CPU, such as the pulse-generator sequencer.

## Interface
- WIDTH, 4: number of PIO data bits serviced (1..32).
- MASK_INIT, {WIDTH{1'b1}}: irq mask written after reset.
- READ_LATENCY, 1: slave readdata latency in clocks after the address is presented (1..3).

- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- address  out  2  slave word address
- chipselect  out  1  slave select
- write_n  out  1  active-low write strobe
- writedata  out  32  write data; bits above WIDTH are 0
- readdata  in  32  slave read data; only [WIDTH-1:0] is used
- irq  in  1  slave interrupt, level
- mask_data  in  WIDTH  new irq mask
- mask_valid  in  1  mask update request
- mask_ready  out  1  high in IDLE; the update is taken when mask_valid & mask_ready
- event_edges  out  WIDTH  captured edge bits
- event_level  out  WIDTH  input levels sampled after the clear
- event_valid  out  1  event present
- event_ready  in  1  consumer accepts the event
- busy  out  1  state != IDLE

## Operation
- FSM states and transitions:
  - INIT: write MASK_INIT to address 2. Next state is IDLE.
  - IDLE: if mask_valid, go to WMASK. Otherwise, if irq, go to RD_CAP. A mask update has priority over irq.
  - WMASK: write mask_data (latched at acceptance) to address 2. Next state is IDLE.
  - RD_CAP: hold address 3 with chipselect=1 and write_n=1 for READ_LATENCY+1 cycles, counted by a latency counter. Latch readdata[WIDTH-1:0] into cap_reg on the last cycle. If cap_reg is 0 (spurious irq), go to IDLE. Otherwise go to CLR.
  - CLR: single-cycle write to address 3 with writedata = 0. The slave clears all capture bits. Next state is RD_LVL.
  - RD_LVL: hold address 0 for READ_LATENCY+1 cycles and latch lvl_reg on the last cycle. Next state is EMIT.
  - EMIT: event_valid=1 with event_edges=cap_reg and event_level=lvl_reg, held stable until event_valid & event_ready. Next state is IDLE.
- Writes last exactly one cycle (chipselect=1, write_n=0). The slave has no waitrequest.
- Edges arriving between the RD_CAP sample and the CLR write are lost, because the slave's clear is unconditional. An edge arriving after CLR re-asserts irq and is serviced after EMIT completes.
- While in EMIT, irq is ignored. No event is ever dropped; back-pressure stalls servicing.
- Bus outputs outside active read/write cycles: chipselect=0, write_n=1, address=0, writedata=0.

## Timing
- All outputs are registered.
- Reset values:
  - state=INIT, so busy=1.
  - chipselect=0, write_n=1, address=0, writedata=0.
  - event_valid=0, event_edges=0, event_level=0.
  - mask_ready=0.
- The first clock after reset deassertion enters INIT. The mask write is visible on the bus in the next cycle.
- irq seen high in IDLE at cycle t (with READ_LATENCY=1):
  - RD_CAP drives the bus in t+1..t+2; sample at the end of t+2.
  - CLR write in t+3.
  - RD_LVL in t+4..t+5.
  - event_valid=1 from t+6.
- Each extra READ_LATENCY cycle adds one cycle to each read.
- If event_ready is already high when event_valid rises, the handshake completes in that cycle. IDLE follows next cycle, and irq is re-evaluated there.
- Asynchronous reset mid-transaction aborts immediately. There is no partial-write recovery; INIT rewrites the mask.

## Structure
- A shared package holds:
  - the state enum;
  - address constants ADDR_DATA=0, ADDR_MASK=2, ADDR_CAP=3;
  - the bus-idle defaults.
- One sub-module, pio_read_seq: the READ_LATENCY counter plus sample strobe, instantiated once and reused by RD_CAP and RD_LVL.

## Test plan
- Reset release with MASK_INIT=4'hF: exactly one write of 0xF to address 2, then IDLE with busy=0 and mask_ready=1.
- Slave model: pulse in_port bit 1, event_ready held high. Required response: read of address 3 returns 0x2, write to address 3, read of address 0. Event shows edges=0x2 and level equal to the current in_port, valid at t+6.
- event_ready held low for 10 cycles while a second edge (bit 3) occurs. First event stays stable. After it is accepted, a second event with edges=0x8 follows.
- mask_valid and irq rise in the same IDLE cycle, mask_data=0x1. The mask write goes out first, then the irq is serviced.
- Spurious irq forced high with capture register 0: read of address 3 only, no clear write, no event, return to IDLE.
- reset_n asserted during CLR: bus returns to idle values immediately, event_valid=0, INIT sequence reruns. Repeat the scenarios with READ_LATENCY=2 and check the added sample cycles.
